field_buffer: RTL and testbench

- Double-buffered cell storage that serves `next_field_iter`.
- Each cycle it registers the cell state and 8 toroidal neighbours at `next_field_iter`'s requested next address (`o_next_x`/`o_next_y`), to be consumed the following cycle.
- It writes `next_field_iter`'s computed new cell state into the opposite (write) field.
- It also provides a host load port for initial patterns and a display read port for the video path.

---
 rtl/field_buffer.sv | 126 ++++++++++++
 tb/tb_field_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/field_buffer.sv
// Double-buffered cell storage for the life iterator: fetch port with toroidal neighbourhood,
// write-back into the opposite field, host load port and display read port.
// Optional FIELD_BUF_INIT_GLIDER_EN: reset seeds a glider into FIELD_A.
module field_buffer #(
  parameter int unsigned FIELD_W    = 5,
  parameter int unsigned FIELD_H    = 3,
  parameter int unsigned X_ADR_SIZE = $clog2(FIELD_W),
  parameter int unsigned Y_ADR_SIZE = $clog2(FIELD_H),
  localparam int unsigned NEIGHBOURS_CNT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_is_simulating,
  input  logic                      i_cur_read_field,
  input  logic [X_ADR_SIZE-1:0]     i_next_x,
  input  logic [Y_ADR_SIZE-1:0]     i_next_y,
  input  logic [X_ADR_SIZE-1:0]     i_cur_x,
  input  logic [Y_ADR_SIZE-1:0]     i_cur_y,
  input  logic                      i_new_cur_cell_state,
  output logic                      o_next_cell_state,
  output logic [NEIGHBOURS_CNT-1:0] o_next_nbrs,
  input  logic                      i_load_we,
  input  logic [X_ADR_SIZE-1:0]     i_load_x,
  input  logic [Y_ADR_SIZE-1:0]     i_load_y,
  input  logic                      i_load_data,
  output logic                      o_load_err,
  input  logic [X_ADR_SIZE-1:0]     i_disp_x,
  input  logic [Y_ADR_SIZE-1:0]     i_disp_y,
  output logic                      o_disp_cell
);

  localparam int unsigned CELLS = FIELD_W * FIELD_H;
  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

`ifdef FIELD_BUF_INIT_GLIDER_EN
  // Glider cells (1,0),(2,1),(0,2),(1,2),(2,2), row-major index y*FIELD_W+x.
  localparam logic [CELLS-1:0] INIT_A = (CELLS'(1) << 1)
                                      | (CELLS'(1) << (FIELD_W + 2))
                                      | (CELLS'(1) << (2 * FIELD_W))
                                      | (CELLS'(1) << (2 * FIELD_W + 1))
                                      | (CELLS'(1) << (2 * FIELD_W + 2));
`else
  localparam logic [CELLS-1:0] INIT_A = '0;
`endif

  function automatic logic [IDX_W-1:0] cell_idx(input logic [X_ADR_SIZE-1:0] x,
                                                input logic [Y_ADR_SIZE-1:0] y);
    int unsigned lin;
    lin = 32'(y) * FIELD_W + 32'(x);
    return lin[IDX_W-1:0];
  endfunction

  // mem_q[0] is FIELD_A, mem_q[1] is FIELD_B.
  logic [1:0][CELLS-1:0] mem_q;
  logic [CELLS-1:0]      rd_field;

  logic                      next_state_q, next_state_d;
  logic [NEIGHBOURS_CNT-1:0] next_nbrs_q, next_nbrs_d;
  logic                      load_err_q, load_err_d;
  logic                      disp_cell_q, disp_cell_d;

  logic                  fetch_ok, disp_ok, load_ok, wb_ok;
  logic [X_ADR_SIZE-1:0] xm, xp;
  logic [Y_ADR_SIZE-1:0] ym, yp;

  assign rd_field = mem_q[i_cur_read_field];

  always_comb begin
    xm = (i_next_x == '0) ? X_MAX : i_next_x - 1'b1;
    xp = (i_next_x == X_MAX) ? '0 : i_next_x + 1'b1;
    ym = (i_next_y == '0) ? Y_MAX : i_next_y - 1'b1;
    yp = (i_next_y == Y_MAX) ? '0 : i_next_y + 1'b1;
    fetch_ok = (i_next_x <= X_MAX) && (i_next_y <= Y_MAX);
    next_state_d = 1'b0;
    next_nbrs_d  = '0;
    if (fetch_ok) begin
      next_state_d = rd_field[cell_idx(i_next_x, i_next_y)];
      next_nbrs_d  = {rd_field[cell_idx(xp, yp)],
                      rd_field[cell_idx(i_next_x, yp)],
                      rd_field[cell_idx(xm, yp)],
                      rd_field[cell_idx(xp, i_next_y)],
                      rd_field[cell_idx(xm, i_next_y)],
                      rd_field[cell_idx(xp, ym)],
                      rd_field[cell_idx(i_next_x, ym)],
                      rd_field[cell_idx(xm, ym)]};
    end
  end

  always_comb begin
    disp_ok     = (i_disp_x <= X_MAX) && (i_disp_y <= Y_MAX);
    disp_cell_d = disp_ok ? rd_field[cell_idx(i_disp_x, i_disp_y)] : 1'b0;
    load_ok     = i_load_we && !i_is_simulating && (i_load_x <= X_MAX) && (i_load_y <= Y_MAX);
    load_err_d  = i_load_we && !load_ok;
    wb_ok       = i_is_simulating && (i_cur_x <= X_MAX) && (i_cur_y <= Y_MAX);
  end

  // Loads only happen when not simulating, so the two writes never target the same field.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q        <= {{CELLS{1'b0}}, INIT_A};
      next_state_q <= 1'b0;
      next_nbrs_q  <= '0;
      load_err_q   <= 1'b0;
      disp_cell_q  <= 1'b0;
    end else begin
      if (wb_ok) begin
        mem_q[~i_cur_read_field][cell_idx(i_cur_x, i_cur_y)] <= i_new_cur_cell_state;
      end
      if (load_ok) begin
        mem_q[i_cur_read_field][cell_idx(i_load_x, i_load_y)] <= i_load_data;
      end
      next_state_q <= next_state_d;
      next_nbrs_q  <= next_nbrs_d;
      load_err_q   <= load_err_d;
      disp_cell_q  <= disp_cell_d;
    end
  end

  assign o_next_cell_state = next_state_q;
  assign o_next_nbrs       = next_nbrs_q;
  assign o_load_err        = load_err_q;
  assign o_disp_cell       = disp_cell_q;

endmodule

// File: tb/tb_field_buffer.sv
// Directed bench for field_buffer: array-based model checked every cycle, plus literal
// expectations for the hand-computed scenarios.
module tb_field_buffer;
  localparam int W  = 5;
  localparam int H  = 3;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sim = 1'b0;
  logic rf = 1'b0;
  logic [XW-1:0] next_x = '0, cur_x = '0, load_x = '0, disp_x = '0;
  logic [YW-1:0] next_y = '0, cur_y = '0, load_y = '0, disp_y = '0;
  logic new_state = 1'b0, load_we = 1'b0, load_data = 1'b0;
  logic st, err, dc;
  logic [7:0] nb;

  int checks = 0;
  int failures = 0;

  bit mf[2][H][W];
  logic exp_st = 1'b0, exp_err = 1'b0, exp_dc = 1'b0;
  logic [7:0] exp_nb = '0;
  bit cmp_en = 1'b0;

  field_buffer #(.FIELD_W(W), .FIELD_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .i_is_simulating(sim), .i_cur_read_field(rf),
    .i_next_x(next_x), .i_next_y(next_y), .i_cur_x(cur_x), .i_cur_y(cur_y),
    .i_new_cur_cell_state(new_state), .o_next_cell_state(st), .o_next_nbrs(nb),
    .i_load_we(load_we), .i_load_x(load_x), .i_load_y(load_y), .i_load_data(load_data),
    .o_load_err(err), .i_disp_x(disp_x), .i_disp_y(disp_y), .o_disp_cell(dc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one clock edge: outputs come from pre-edge contents, then writes land.
  task automatic model_edge();
    int ix, iy, k;
    if (!rst_n) begin
      foreach (mf[f, y, x]) mf[f][y][x] = 1'b0;
`ifdef FIELD_BUF_INIT_GLIDER_EN
      mf[0][0][1] = 1'b1;
      mf[0][1][2] = 1'b1;
      mf[0][2][0] = 1'b1;
      mf[0][2][1] = 1'b1;
      mf[0][2][2] = 1'b1;
`endif
      exp_st = 1'b0; exp_nb = '0; exp_err = 1'b0; exp_dc = 1'b0;
    end else begin
      ix = int'(next_x);
      iy = int'(next_y);
      exp_st = 1'b0;
      exp_nb = '0;
      if (ix < W && iy < H) begin
        exp_st = mf[rf][iy][ix];
        k = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (!(dx == 0 && dy == 0)) begin
              exp_nb[k] = mf[rf][(iy + dy + H) % H][(ix + dx + W) % W];
              k++;
            end
          end
        end
      end
      exp_dc = (int'(disp_x) < W && int'(disp_y) < H) ? mf[rf][disp_y][disp_x] : 1'b0;
      exp_err = load_we && (sim || int'(load_x) >= W || int'(load_y) >= H);
      if (sim && int'(cur_x) < W && int'(cur_y) < H) mf[!rf][cur_y][cur_x] = new_state;
      if (load_we && !sim && int'(load_x) < W && int'(load_y) < H)
        mf[rf][load_y][load_x] = load_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_state", {7'b0, st}, {7'b0, exp_st});
      chk("model_nbrs", nb, exp_nb);
      chk("model_err", {7'b0, err}, {7'b0, exp_err});
      chk("model_disp", {7'b0, dc}, {7'b0, exp_dc});
    end
  end

  task automatic load(input int x, input int y, input logic d);
    load_we = 1'b1; load_x = XW'(x); load_y = YW'(y); load_data = d;
    step();
    load_we = 1'b0;
  endtask

  task automatic fetch(input int x, input int y);
    next_x = XW'(x); next_y = YW'(y);
    step();
  endtask

  task automatic disp_scan();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        disp_x = XW'(x); disp_y = YW'(y);
        step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic p;
    repeat (3) step();
    chk("reset_state", {7'b0, st}, 8'h00);
    chk("reset_nbrs", nb, 8'h00);
    chk("reset_err", {7'b0, err}, 8'h00);
    chk("reset_disp", {7'b0, dc}, 8'h00);
    rst_n = 1'b1;

`ifdef FIELD_BUF_INIT_GLIDER_EN
    fetch(1, 1);
    chk("glider_state_1_1", {7'b0, st}, 8'h00);
    chk("glider_nbrs_1_1", nb, 8'hF2);
    fetch(1, 0);
    chk("glider_state_1_0", {7'b0, st}, 8'h01);
`else
    fetch(2, 1);
    chk("t1_state", {7'b0, st}, 8'h00);
    chk("t1_nbrs", nb, 8'h00);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        disp_x = XW'(x); disp_y = YW'(y);
        step();
        chk("t1_disp_zero", {7'b0, dc}, 8'h00);
      end
    end

    // Corner wrap
    load(4, 2, 1'b1);
    fetch(0, 0);
    chk("t2_nbrs_0_0", nb, 8'h01);
    chk("t2_state_0_0", {7'b0, st}, 8'h00);
    fetch(4, 2);
    chk("t2_state_4_2", {7'b0, st}, 8'h01);
    chk("t2_nbrs_4_2", nb, 8'h00);

    // Full neighbourhood of (2,1)
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        load(2 + dx, 1 + dy, !(dx == 0 && dy == 0));
    fetch(2, 1);
    chk("t3_state", {7'b0, st}, 8'h00);
    chk("t3_nbrs_full", nb, 8'hFF);
    load(3, 1, 1'b0);
    fetch(2, 1);
    chk("t3_nbrs_cleared", nb, 8'hEF);

    // Load and fetch of the same cell in one cycle
    next_x = 3'd2; next_y = 2'd1;
    load(2, 1, 1'b1);
    chk("same_cell_old", {7'b0, st}, 8'h00);
    fetch(2, 1);
    chk("same_cell_new", {7'b0, st}, 8'h01);
`endif

    // Out-of-range fetch, load and display
    fetch(7, 3);
    chk("oor_fetch_state", {7'b0, st}, 8'h00);
    chk("oor_fetch_nbrs", nb, 8'h00);
    load(5, 0, 1'b1);
    chk("oor_load_err", {7'b0, err}, 8'h01);
    disp_x = 3'd6; disp_y = 2'd0;
    step();
    chk("oor_load_err_clears", {7'b0, err}, 8'h00);
    chk("oor_disp", {7'b0, dc}, 8'h00);

    // Write-back of x^y parity into FIELD_B while reading FIELD_A
    sim = 1'b1; rf = 1'b0; next_x = 3'd1; next_y = 2'd1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        cur_x = XW'(x); cur_y = YW'(y); new_state = ^(x ^ y);
        step();
      end
    end
    sim = 1'b0; rf = 1'b1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        disp_x = XW'(x); disp_y = YW'(y);
        step();
        p = ^(x ^ y);
        chk("t4_field_b", {7'b0, dc}, {7'b0, p});
      end
    end
    rf = 1'b0;
    disp_scan();

    // Load during simulation is rejected
    sim = 1'b1; rf = 1'b0; cur_x = '0; cur_y = '0; new_state = 1'b0;
    load(1, 1, 1'b1);
    chk("t5_err_pulse", {7'b0, err}, 8'h01);
    step();
    chk("t5_err_one_cycle", {7'b0, err}, 8'h00);
    sim = 1'b0;
    disp_x = 3'd1; disp_y = 2'd1; rf = 1'b1;
    step();
    chk("t5_b_1_1", {7'b0, dc}, 8'h00);
`ifndef FIELD_BUF_INIT_GLIDER_EN
    rf = 1'b0;
    step();
    chk("t5_a_1_1", {7'b0, dc}, 8'h01);
`endif

    // Reset in the middle of a simulation pass
    sim = 1'b1; rf = 1'b0; cur_x = 3'd2; cur_y = 2'd2; new_state = 1'b1;
    next_x = 3'd2; next_y = 2'd1;
    rst_n = 1'b0;
    step();
    chk("midrst_state", {7'b0, st}, 8'h00);
    chk("midrst_nbrs", nb, 8'h00);
    rst_n = 1'b1; sim = 1'b0;
    rf = 1'b1;
    disp_scan();
    rf = 1'b0;
    disp_scan();
`ifndef FIELD_BUF_INIT_GLIDER_EN
    fetch(2, 1);
    chk("midrst_cleared_nbrs", nb, 8'h00);
`endif

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
